// File: rtl/ps2_mouse_pkg.sv
// ---------------------------------------------------------------------------
// ps2_mouse_pkg
//   Shared types and constants for the PS/2 mouse packet decoder.
//   - byte0_t : layout of the first byte of a standard 3-byte mouse packet
//   - state_t : packet framing FSM states
//   - DELTA_MAX / DELTA_MIN : saturation values used when an overflow bit is set
//   - decode_delta() : builds a 9-bit signed delta from sign, overflow, magnitude
// ---------------------------------------------------------------------------
package ps2_mouse_pkg;

    localparam int DELTA_W   = 9;
    localparam int DELTA_MAX = 255;
    localparam int DELTA_MIN = -256;

    // Byte 0 of a standard mouse packet, MSB first.
    typedef struct packed {
        logic y_ovf;
        logic x_ovf;
        logic y_sign;
        logic x_sign;
        logic always_one;   // framing marker, set in every valid header byte
        logic middle;
        logic right;
        logic left;
    } byte0_t;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        APPLY   = 2'd3
    } state_t;

    // An overflowed axis reports a meaningless magnitude, so it is replaced
    // by the extreme value in the direction given by the sign bit.
    function automatic logic signed [DELTA_W-1:0] decode_delta(
        input logic       ovf,
        input logic       sign,
        input logic [7:0] mag
    );
        logic signed [DELTA_W-1:0] d;
        if (ovf) begin
            d = sign ? DELTA_W'(DELTA_MIN) : DELTA_W'(DELTA_MAX);
        end else begin
            d = $signed({sign, mag});
        end
        return d;
    endfunction

endpackage

// File: rtl/ps2_axis_accum.sv
// ---------------------------------------------------------------------------
// ps2_axis_accum
//   Combinational per-axis position update: scales a 9-bit signed delta by an
//   arithmetic right shift, adds (or subtracts, when INVERT) it to the current
//   position in a widened signed domain, and clamps the result to [0, LIMIT-1].
//
//   Parameters
//     W      : position width, 2**W >= LIMIT
//     LIMIT  : number of valid positions on this axis
//     SHIFT  : sensitivity shift applied to the delta
//     INVERT : 1 = subtract the delta instead of adding it
//   Ports
//     pos      in  W        current position
//     delta    in  9 (s)    saturated delta from the packet
//     next_pos out W        clamped new position
// ---------------------------------------------------------------------------
module ps2_axis_accum
    import ps2_mouse_pkg::*;
#(
    parameter int W      = 10,
    parameter int LIMIT  = 640,
    parameter int SHIFT  = 0,
    parameter bit INVERT = 1'b0
) (
    input  logic [W-1:0]                pos,
    input  logic signed [DELTA_W-1:0]   delta,
    output logic [W-1:0]                next_pos
);

    // Two guard bits above the wider of position and delta: one for the
    // sign, one so that pos + delta can never wrap before clamping.
    localparam int SW = ((W > DELTA_W) ? W : DELTA_W) + 2;
    localparam logic signed [SW-1:0] MAX_POS = SW'(LIMIT - 1);

    logic signed [DELTA_W-1:0] scaled;
    logic signed [SW-1:0]      step;
    logic signed [SW-1:0]      base;
    logic signed [SW-1:0]      sum;

    // NOTE: every combinational output gets a value before any branch, so no
    // path through the block leaves a signal holding its old value (no latch).
    always_comb begin
        scaled   = delta >>> SHIFT;
        step     = SW'(scaled);
        base     = $signed(SW'(pos));
        sum      = INVERT ? (base - step) : (base + step);
        next_pos = sum[W-1:0];
        if (sum < 0) begin
            next_pos = '0;
        end else if (sum > MAX_POS) begin
            next_pos = W'(LIMIT - 1);
        end
    end

endmodule

// File: rtl/ps2_mouse_pkt_decoder.sv
// ---------------------------------------------------------------------------
// ps2_mouse_pkt_decoder
//   Frames the byte stream from a PS/2 receiver into standard 3-byte mouse
//   packets, decodes saturated 9-bit deltas, and keeps a screen-clamped cursor
//   and button state for display logic.
//
//   Ports
//     clk        in   1     system clock
//     rstn       in   1     asynchronous active-low reset
//     rx_valid   in   1     one-cycle strobe, rx_byte valid
//     rx_byte    in   8     received byte
//     recenter   in   1     move cursor to the screen centre on the next edge
//     pkt_valid  out  1     one-cycle strobe, a packet was applied
//     sync_err   out  1     one-cycle strobe, byte dropped or packet aborted
//     buttons    out  3     {middle, right, left} of the last packet
//     dx, dy     out  9 (s) saturated deltas of the last packet, unscaled
//     cursor_x   out  X_W   cursor X in [0, SCREEN_W-1]
//     cursor_y   out  Y_W   cursor Y in [0, SCREEN_H-1]
// ---------------------------------------------------------------------------
module ps2_mouse_pkt_decoder
    import ps2_mouse_pkg::*;
#(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int TIMEOUT_CYC = 50000,
    parameter int SHIFT       = 0,
    parameter bit INVERT_Y    = 1'b1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_byte,
    input  logic                      recenter,
    output logic                      pkt_valid,
    output logic                      sync_err,
    output logic [2:0]                buttons,
    output logic signed [DELTA_W-1:0] dx,
    output logic signed [DELTA_W-1:0] dy,
    output logic [X_W-1:0]            cursor_x,
    output logic [Y_W-1:0]            cursor_y
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [X_W-1:0]   CENTRE_X = X_W'(SCREEN_W / 2);
    localparam logic [Y_W-1:0]   CENTRE_Y = Y_W'(SCREEN_H / 2);

    state_t            state;
    state_t            state_next;
    byte0_t            rx_hdr;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [CNT_W-1:0]  tmo_next;
    logic              tmo_hit;
    logic              tmo_fire;
    logic              bad_hdr;
    logic              in_apply;
    logic              defer_q;
    logic              defer_next;
    logic              sync_err_next;
    logic              ld_b0;
    logic              ld_b1;
    logic              ld_b2;

    // Latched packet fields (the byte-0 framing marker is not kept).
    logic [2:0]        btn_q;
    logic              x_ovf_q;
    logic              y_ovf_q;
    logic              x_sign_q;
    logic              y_sign_q;
    logic [7:0]        b1_q;
    logic [7:0]        b2_q;

    logic signed [DELTA_W-1:0] dx_dec;
    logic signed [DELTA_W-1:0] dy_dec;
    logic [X_W-1:0]            x_upd;
    logic [Y_W-1:0]            y_upd;

    assign rx_hdr   = byte0_t'(rx_byte);
    assign in_apply = (state == APPLY);
    assign tmo_hit  = (tmo_cnt == TMO_LAST);

    // -----------------------------------------------------------------------
    // Next-state and strobe logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        ld_b0      = 1'b0;
        ld_b1      = 1'b0;
        ld_b2      = 1'b0;
        bad_hdr    = 1'b0;
        tmo_fire   = 1'b0;

        case (state)
            // APPLY lasts one cycle; a byte arriving during it is judged as
            // a header candidate exactly as in WAIT_B0, so it is not lost.
            WAIT_B0, APPLY: begin
                state_next = WAIT_B0;
                if (rx_valid) begin
                    if (rx_hdr.always_one) begin
                        ld_b0      = 1'b1;
                        state_next = WAIT_B1;
                    end else begin
                        bad_hdr = 1'b1;
                    end
                end
            end
            WAIT_B1: begin
                if (rx_valid) begin
                    ld_b1      = 1'b1;
                    state_next = WAIT_B2;
                end else if (tmo_hit) begin
                    tmo_fire   = 1'b1;
                    state_next = WAIT_B0;
                end
            end
            WAIT_B2: begin
                if (rx_valid) begin
                    ld_b2      = 1'b1;
                    state_next = APPLY;
                end else if (tmo_hit) begin
                    tmo_fire   = 1'b1;
                    state_next = WAIT_B0;
                end
            end
            default: state_next = WAIT_B0;
        endcase
    end

    // Inter-byte counter: advances only while waiting for byte 1 or 2 with
    // nothing arriving; any accepted byte, timeout or other state clears it.
    always_comb begin
        tmo_next = '0;
        if ((state == WAIT_B1 || state == WAIT_B2) && !rx_valid && !tmo_hit) begin
            tmo_next = tmo_cnt + CNT_W'(1);
        end
    end

    // A bad header seen during APPLY would pulse sync_err in the same cycle
    // as pkt_valid, so its pulse is pushed back one cycle. While a deferred
    // pulse is going out, a further bad header is deferred again, so every
    // dropped byte still yields exactly one sync_err pulse. Timeouts only
    // happen in WAIT_B1/B2 and can never meet a deferred pulse (which only
    // exists while the FSM sits in WAIT_B0).
    always_comb begin
        defer_next    = bad_hdr & (in_apply | defer_q);
        sync_err_next = tmo_fire | defer_q | (bad_hdr & ~in_apply & ~defer_q);
    end

    // -----------------------------------------------------------------------
    // Delta decode and per-axis accumulators
    // -----------------------------------------------------------------------
    assign dx_dec = decode_delta(x_ovf_q, x_sign_q, b1_q);
    assign dy_dec = decode_delta(y_ovf_q, y_sign_q, b2_q);

    ps2_axis_accum #(
        .W      (X_W),
        .LIMIT  (SCREEN_W),
        .SHIFT  (SHIFT),
        .INVERT (1'b0)
    ) u_accum_x (
        .pos      (cursor_x),
        .delta    (dx_dec),
        .next_pos (x_upd)
    );

    ps2_axis_accum #(
        .W      (Y_W),
        .LIMIT  (SCREEN_H),
        .SHIFT  (SHIFT),
        .INVERT (INVERT_Y)
    ) u_accum_y (
        .pos      (cursor_y),
        .delta    (dy_dec),
        .next_pos (y_upd)
    );

    // -----------------------------------------------------------------------
    // Control and output registers
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= WAIT_B0;
            tmo_cnt   <= '0;
            defer_q   <= 1'b0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            buttons   <= '0;
            dx        <= '0;
            dy        <= '0;
            cursor_x  <= CENTRE_X;
            cursor_y  <= CENTRE_Y;
        end else begin
            state     <= state_next;
            tmo_cnt   <= tmo_next;
            defer_q   <= defer_next;
            pkt_valid <= in_apply;
            sync_err  <= sync_err_next;

            if (in_apply) begin
                buttons <= btn_q;
                dx      <= dx_dec;
                dy      <= dy_dec;
            end

            // recenter overrides a coincident packet for the cursor only.
            if (recenter) begin
                cursor_x <= CENTRE_X;
                cursor_y <= CENTRE_Y;
            end else if (in_apply) begin
                cursor_x <= x_upd;
                cursor_y <= y_upd;
            end
        end
    end

    // NOTE: packet byte holding registers carry no reset; they are only read
    // in APPLY, which the FSM reaches solely after all three were reloaded.
    always_ff @(posedge clk) begin
        if (ld_b0) begin
            btn_q    <= {rx_hdr.middle, rx_hdr.right, rx_hdr.left};
            x_ovf_q  <= rx_hdr.x_ovf;
            y_ovf_q  <= rx_hdr.y_ovf;
            x_sign_q <= rx_hdr.x_sign;
            y_sign_q <= rx_hdr.y_sign;
        end
        if (ld_b1) begin
            b1_q <= rx_byte;
        end
        if (ld_b2) begin
            b2_q <= rx_byte;
        end
    end

endmodule

// File: tb/tb_ps2_mouse_pkt_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_mouse_pkt_decoder
//   Self-checking bench: directed packets for the documented corner cases,
//   then a randomized byte stream with random gaps and recenter requests.
//   A transaction-level reference model (byte counting, gap timing, integer
//   arithmetic) predicts every applied packet and the number of sync errors.
// ---------------------------------------------------------------------------
module tb_ps2_mouse_pkt_decoder;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int X_W      = 10;
    localparam int Y_W      = 10;
    localparam int T        = 20;    // short inter-byte timeout for simulation
    localparam int SHIFT    = 0;
    localparam bit INVERT_Y = 1'b1;
    localparam int CX       = SCREEN_W / 2;
    localparam int CY       = SCREEN_H / 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              recenter = 1'b0;
    logic              pkt_valid;
    logic              sync_err;
    logic [2:0]        buttons;
    logic signed [8:0] dx;
    logic signed [8:0] dy;
    logic [X_W-1:0]    cursor_x;
    logic [Y_W-1:0]    cursor_y;

    always #5 clk = ~clk;

    ps2_mouse_pkt_decoder #(
        .SCREEN_W    (SCREEN_W),
        .SCREEN_H    (SCREEN_H),
        .X_W         (X_W),
        .Y_W         (Y_W),
        .TIMEOUT_CYC (T),
        .SHIFT       (SHIFT),
        .INVERT_Y    (INVERT_Y)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .recenter  (recenter),
        .pkt_valid (pkt_valid),
        .sync_err  (sync_err),
        .buttons   (buttons),
        .dx        (dx),
        .dy        (dy),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int btn;
        int dx;
        int dy;
        int cx;
        int cy;
        int due;
    } exp_pkt_t;

    exp_pkt_t exp_q[$];
    int cyc      = 0;
    int m_cx     = CX;
    int m_cy     = CY;
    int m_n      = 0;        // bytes of the current packet collected so far
    int m_last   = 0;        // cycle of the last accepted in-packet byte
    int m_bytes[3];
    bit m_pend   = 1'b0;     // packet complete, applied on the next edge
    int p_btn, p_dx, p_dy;
    int exp_err  = 0;
    int obs_err  = 0;
    int obs_pkt  = 0;
    int both_cnt = 0;

    function automatic int sat_delta(input int ovf, input int sign, input int mag);
        if (ovf != 0) return (sign != 0) ? -256 : 255;
        return (sign != 0) ? mag - 256 : mag;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_step(input bit valid, input int b, input bit rec);
        int nx, ny;
        if (m_pend) begin
            nx = clampi(m_cx + (p_dx >>> SHIFT), 0, SCREEN_W - 1);
            ny = INVERT_Y ? m_cy - (p_dy >>> SHIFT) : m_cy + (p_dy >>> SHIFT);
            ny = clampi(ny, 0, SCREEN_H - 1);
            if (rec) begin
                m_cx = CX;
                m_cy = CY;
            end else begin
                m_cx = nx;
                m_cy = ny;
            end
            exp_q.push_back('{p_btn, p_dx, p_dy, m_cx, m_cy, cyc + 1});
            m_pend = 1'b0;
        end else if (rec) begin
            m_cx = CX;
            m_cy = CY;
        end

        if (valid) begin
            if (m_n == 0 && ((b >> 3) & 1) == 0) begin
                exp_err++;
            end else begin
                m_bytes[m_n] = b;
                m_n++;
                m_last = cyc;
                if (m_n == 3) begin
                    p_btn  = m_bytes[0] & 7;
                    p_dx   = sat_delta((m_bytes[0] >> 6) & 1, (m_bytes[0] >> 4) & 1, m_bytes[1]);
                    p_dy   = sat_delta((m_bytes[0] >> 7) & 1, (m_bytes[0] >> 5) & 1, m_bytes[2]);
                    m_pend = 1'b1;
                    m_n    = 0;
                end
            end
        end else if (m_n > 0 && (cyc - m_last) >= T) begin
            exp_err++;
            m_n = 0;
        end
    endtask

    // ------------------------------------------------------------------
    // Drive / sample, one clock per call, on the falling edge
    // ------------------------------------------------------------------
    task automatic sample();
        exp_pkt_t e;
        if (pkt_valid) begin
            obs_pkt++;
            if (exp_q.size() == 0) begin
                check("pkt_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pkt_cycle", cyc, e.due);
                check("pkt_buttons", int'(buttons), e.btn);
                check("pkt_dx", int'(dx), e.dx);
                check("pkt_dy", int'(dy), e.dy);
                check("pkt_cursor_x", int'(cursor_x), e.cx);
                check("pkt_cursor_y", int'(cursor_y), e.cy);
            end
        end
        if (sync_err) obs_err++;
        if (sync_err && pkt_valid) both_cnt++;
    endtask

    task automatic drive(input bit valid, input logic [7:0] b, input bit rec);
        @(negedge clk);
        sample();
        rx_valid = valid;
        rx_byte  = b;
        recenter = rec;
        model_step(valid, int'(b), rec);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        drive(1'b1, b0, 1'b0);
        drive(1'b1, b1, 1'b0);
        drive(1'b1, b2, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int e0, p0;

        repeat (3) @(negedge clk);
        check("rst_cursor_x", int'(cursor_x), CX);
        check("rst_cursor_y", int'(cursor_y), CY);
        check("rst_buttons", int'(buttons), 0);
        check("rst_dx", int'(dx), 0);
        check("rst_pkt_valid", int'(pkt_valid), 0);
        check("rst_sync_err", int'(sync_err), 0);
        rstn = 1'b1;

        idle(4);
        check("idle_no_pkt", obs_pkt, 0);
        check("idle_no_err", obs_err, 0);

        // Basic packet, back-to-back bytes.
        send3(8'h08, 8'h05, 8'h03);
        idle(2);
        check("basic_dx", int'(dx), 5);
        check("basic_dy", int'(dy), 3);
        check("basic_cursor_x", int'(cursor_x), 325);
        check("basic_cursor_y", int'(cursor_y), 237);

        // Walk X down to 5, then clamp at the left edge.
        send3(8'h58, 8'h00, 8'h00);          // x overflow negative: -256
        send3(8'h18, 8'hC0, 8'h00);          // -64
        idle(2);
        check("walk_cursor_x", int'(cursor_x), 5);
        send3(8'h19, 8'hEC, 8'h00);
        idle(2);
        check("clamp_lo_dx", int'(dx), -20);
        check("clamp_lo_cursor_x", int'(cursor_x), 0);
        check("clamp_lo_buttons", int'(buttons), 1);

        // Positive overflow saturation, then clamp on both high X and low Y.
        drive(1'b0, 8'h00, 1'b1);
        idle(1);
        send3(8'h48, 8'h10, 8'h00);
        idle(2);
        check("ovf_dx", int'(dx), 255);
        check("ovf_cursor_x", int'(cursor_x), 575);
        send3(8'hC8, 8'h00, 8'h00);
        idle(2);
        check("ovf2_dy", int'(dy), 255);
        check("clamp_hi_cursor_x", int'(cursor_x), 639);
        check("clamp_cursor_y", int'(cursor_y), 0);

        // Bad header byte.
        e0 = obs_err;
        drive(1'b1, 8'h00, 1'b0);
        idle(2);
        check("bad_hdr_err", obs_err - e0, 1);
        send3(8'h0A, 8'h00, 8'h00);
        idle(2);
        check("right_button", int'(buttons), 2);

        // Timeout after two bytes, then a clean packet.
        e0 = obs_err;
        p0 = obs_pkt;
        drive(1'b1, 8'h08, 1'b0);
        drive(1'b1, 8'h01, 1'b0);
        idle(T + 2);
        check("tmo_err", obs_err - e0, 1);
        check("tmo_no_pkt", obs_pkt - p0, 0);
        send3(8'h08, 8'h02, 8'h00);
        idle(2);
        check("tmo_next_dx", int'(dx), 2);
        check("tmo_next_pkt", obs_pkt - p0, 1);

        // Gaps of T-1 idle cycles must not time out.
        e0 = obs_err;
        p0 = obs_pkt;
        drive(1'b1, 8'h08, 1'b0);
        idle(T - 1);
        drive(1'b1, 8'h01, 1'b0);
        idle(T - 1);
        drive(1'b1, 8'h00, 1'b0);
        idle(2);
        check("gap_edge_pkt", obs_pkt - p0, 1);
        check("gap_edge_no_err", obs_err - e0, 0);

        // recenter on the APPLY edge.
        p0 = obs_pkt;
        send3(8'h08, 8'h10, 8'h10);
        drive(1'b0, 8'h00, 1'b1);
        idle(2);
        check("rec_apply_pkt", obs_pkt - p0, 1);
        check("rec_apply_cx", int'(cursor_x), CX);
        check("rec_apply_cy", int'(cursor_y), CY);
        check("rec_apply_dx", int'(dx), 16);

        // Header arriving during APPLY is kept; bad one during APPLY is flagged.
        p0 = obs_pkt;
        e0 = obs_err;
        send3(8'h08, 8'h01, 8'h00);
        send3(8'h08, 8'h01, 8'h00);
        drive(1'b1, 8'h00, 1'b0);
        idle(3);
        check("apply_back2back_pkt", obs_pkt - p0, 2);
        check("apply_bad_err", obs_err - e0, 1);

        // Randomized stream.
        for (int k = 0; k < 600; k++) begin
            int r, gap;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 50)      gap = 0;
            else if (r < 85) gap = $urandom_range(1, 3);
            else if (r < 92) gap = T - 1;
            else if (r < 96) gap = T;
            else             gap = T + 2;
            for (int g = 0; g < gap; g++) drive(1'b0, 8'($urandom), $urandom_range(0, 59) == 0);
            b = 8'($urandom);
            if (k % 3 == 0) begin
                if ($urandom_range(0, 9) != 0) b[3] = 1'b1;
                if ($urandom_range(0, 4) != 0) b[7:6] = 2'b00;
            end
            drive(1'b1, b, $urandom_range(0, 59) == 0);
        end
        idle(T + 5);

        check("final_pkts_pending", exp_q.size(), 0);
        check("final_sync_err_count", obs_err, exp_err);
        check("final_both_strobes", both_cnt, 0);
        check("final_cursor_x", int'(cursor_x), m_cx);
        check("final_cursor_y", int'(cursor_y), m_cy);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
